sw_debounce: RTL and testbench

- Switch-input conditioner that produces the clean `sw_in` vector consumed by the DUT's switch/LED interface (WIDTH bits).
- Raw, asynchronous, bouncing switch levels are synchronized, debounced per bit, and presented as stable levels plus one-cycle rise/fall pulses.
- Sits between the board/bench raw switch pins and the `sw_in` field of the DUT interface.

---
 rtl/sw_debounce.sv | 105 ++++++++++
 tb/tb_sw_debounce.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Switch-input conditioner: per-bit synchronizer, stability counter and
// registered rise/fall pulses producing the clean sw_in vector.
module sw_debounce #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("sw_debounce: WIDTH must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("sw_debounce: SYNC_STAGES must be >= 2");
      end
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("sw_debounce: STABLE_CYCLES must be >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_s;

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] flip_d;

   logic [WIDTH-1:0] sw_in_q,   sw_in_d;
   logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
   logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
   logic             sw_changed_q, sw_changed_d;

   // NOTE: the whole synchronizer array is reset so sw_in cannot flip on stale
   // pre-reset samples; every flop here is state, so <= is used throughout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= sw_raw;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // NOTE: defaults first so no path through this block leaves a latch.
   always_comb begin
      flip_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_s[i] != sw_in_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               flip_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      sw_in_d      = sw_in_q ^ flip_d;
      sw_rise_d    = flip_d & sync_s;
      sw_fall_d    = flip_d & ~sync_s;
      sw_changed_d = |flip_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         sw_in_q      <= '0;
         sw_rise_q    <= '0;
         sw_fall_q    <= '0;
         sw_changed_q <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         sw_in_q      <= sw_in_d;
         sw_rise_q    <= sw_rise_d;
         sw_fall_q    <= sw_fall_d;
         sw_changed_q <= sw_changed_d;
      end
   end

   assign sw_in      = sw_in_q;
   assign sw_rise    = sw_rise_q;
   assign sw_fall    = sw_fall_q;
   assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomized and directed bench for sw_debounce, checking a STABLE_CYCLES=4 and
// a STABLE_CYCLES=1 instance against a sample-window reference model.
module tb_sw_debounce;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw_raw = 8'h00;

   logic [7:0] in4, rise4, fall4;
   logic       chg4;
   logic [7:0] in1, rise1, fall1;
   logic       chg1;

   sw_debounce #(.WIDTH(8), .SYNC_STAGES(SYNC), .STABLE_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
      .sw_in(in4), .sw_rise(rise4), .sw_fall(fall4), .sw_changed(chg4)
   );

   sw_debounce #(.WIDTH(8), .SYNC_STAGES(SYNC), .STABLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
      .sw_in(in1), .sw_rise(rise1), .sw_fall(fall1), .sw_changed(chg1)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference: hist[k] is sw_raw sampled k+1 edges ago. A bit flips at an edge
   // when the last STABLE synchronized samples all differ from the output.
   logic [7:0] hist [0:5];
   logic [7:0] m4_in, m4_rise, m4_fall;
   logic       m4_chg;
   logic [7:0] m1_in, m1_rise, m1_fall;
   logic       m1_chg;

   function automatic logic [7:0] flips(input int stable, input logic [7:0] out);
      logic [7:0] f;
      for (int i = 0; i < 8; i++) begin
         f[i] = 1'b1;
         for (int k = SYNC - 1; k <= SYNC + stable - 2; k++) begin
            if (hist[k][i] == out[i]) f[i] = 1'b0;
         end
      end
      return f;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 6; k++) hist[k] = 8'h00;
      m4_in = 0; m4_rise = 0; m4_fall = 0; m4_chg = 0;
      m1_in = 0; m1_rise = 0; m1_fall = 0; m1_chg = 0;
   endtask

   task automatic model_edge(input logic [7:0] raw);
      logic [7:0] f;
      if (!rst_n) begin
         model_clear();
         return;
      end
      f = flips(4, m4_in);
      m4_rise = f & ~m4_in; m4_fall = f & m4_in; m4_chg = |f; m4_in = m4_in ^ f;
      f = flips(1, m1_in);
      m1_rise = f & ~m1_in; m1_fall = f & m1_in; m1_chg = |f; m1_in = m1_in ^ f;
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw;
   endtask

   task automatic step(input logic [7:0] raw);
      @(negedge clk);
      sw_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
   endtask

   function automatic logic [24:0] got4();
      return {in4, rise4, fall4, chg4};
   endfunction
   function automatic logic [24:0] got1();
      return {in1, rise1, fall1, chg1};
   endfunction
   function automatic logic [24:0] exp4();
      return {m4_in, m4_rise, m4_fall, m4_chg};
   endfunction
   function automatic logic [24:0] exp1();
      return {m1_in, m1_rise, m1_fall, m1_chg};
   endfunction

   task automatic test_reset();
      model_clear();
      rst_n = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step(8'($urandom));
         n_total++;
         if (got4() !== 25'd0 || got1() !== 25'd0) begin
            $display("FAIL reset: dut4=%h dut1=%h required 0", got4(), got1());
         end else n_pass++;
      end
      sw_raw = 8'h00;
      #2 rst_n = 1'b1;
   endtask

   task automatic test_single_rise();
      int rises = 0, falls = 0;
      logic [7:0] stim [$];
      for (int j = 0; j < 8; j++) stim.push_back(8'h00);
      for (int j = 0; j < 10; j++) stim.push_back(8'h01);
      foreach (stim[j]) begin
         step(stim[j]);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL single_rise[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         if (j >= 8 && rise4 != 0) rises++;
         if (j >= 8 && fall4 != 0) falls++;
         if (j == 12 || j == 13) begin
            n_total++;
            if (in4 !== ((j == 13) ? 8'h01 : 8'h00)) begin
               $display("FAIL single_rise_latency e%0d: sw_in=%h", j - 8, in4);
            end else n_pass++;
         end
         if (j == 9 || j == 10) begin
            n_total++;
            if (in1 !== ((j == 10) ? 8'h01 : 8'h00)) begin
               $display("FAIL single_rise_latency1 e%0d: sw_in=%h", j - 8, in1);
            end else n_pass++;
         end
      end
      n_total++;
      if (rises != 1 || falls != 0) begin
         $display("FAIL single_rise_pulses: rises=%0d falls=%0d required 1/0", rises, falls);
      end else n_pass++;
   endtask

   task automatic test_stable_one();
      logic [7:0] stim [$];
      for (int j = 0; j < 8; j++) stim.push_back(8'h00);
      for (int j = 0; j < 5; j++) stim.push_back(8'h80);
      stim.push_back(8'h81);
      for (int j = 0; j < 6; j++) stim.push_back(8'h80);
      foreach (stim[j]) begin
         step(stim[j]);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL stable_one[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         if (j == 10) begin
            n_total++;
            if (in1 !== 8'h80) $display("FAIL stable_one_latency: sw_in=%h required 80", in1);
            else n_pass++;
         end
         if (j == 15 || j == 16) begin
            n_total++;
            if ({in1, rise1, fall1} !== ((j == 15) ? {8'h81, 8'h01, 8'h00} : {8'h80, 8'h00, 8'h01})) begin
               $display("FAIL stable_one_glitch e%0d: in=%h rise=%h fall=%h", j, in1, rise1, fall1);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_glitch();
      logic [7:0] stim [$];
      stim.push_back(8'h80);
      stim.push_back(8'h88);
      stim.push_back(8'h88);
      for (int j = 0; j < 10; j++) stim.push_back(8'h80);
      foreach (stim[j]) begin
         step(stim[j]);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL glitch[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         n_total++;
         if (in4[3] !== 1'b0 || rise4 !== 8'h00 || chg4 !== 1'b0) begin
            $display("FAIL glitch_reject[%0d]: in=%h rise=%h chg=%b", j, in4, rise4, chg4);
         end else n_pass++;
      end
   endtask

   task automatic test_bounce();
      int rises = 0;
      logic [7:0] stim [$];
      for (int j = 0; j < 8; j++) stim.push_back(8'h00);
      stim.push_back(8'h80); stim.push_back(8'h00); stim.push_back(8'h80);
      stim.push_back(8'h00);
      for (int j = 0; j < 11; j++) stim.push_back(8'h80);
      foreach (stim[j]) begin
         step(stim[j]);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL bounce[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         if (j >= 8 && rise4[7]) rises++;
         if (j == 16 || j == 17) begin
            n_total++;
            if (in4[7] !== (j == 17)) $display("FAIL bounce_latency e%0d: sw_in=%h", j, in4);
            else n_pass++;
         end
      end
      n_total++;
      if (rises != 1) $display("FAIL bounce_pulses: rises=%0d required 1", rises);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] stim [$];
      for (int j = 0; j < 8; j++) stim.push_back(8'hFF);
      for (int j = 0; j < 8; j++) stim.push_back(8'h5A);
      foreach (stim[j]) begin
         step(stim[j]);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL simultaneous[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         if (j == 12 || j == 13 || j == 14) begin
            n_total++;
            if (got4() !== ((j == 12) ? {8'hFF, 8'h00, 8'h00, 1'b0} :
                            (j == 13) ? {8'h5A, 8'h00, 8'hA5, 1'b1} :
                                        {8'h5A, 8'h00, 8'h00, 1'b0})) begin
               $display("FAIL simultaneous_edge e%0d: in/rise/fall/chg=%h", j, got4());
            end else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int j = 0; j < 8; j++) step(8'hF0);
      n_total++;
      if (in4 !== 8'hF0) $display("FAIL reset_mid_setup: sw_in=%h required F0", in4);
      else n_pass++;
      for (int j = 0; j < 3; j++) step(8'h0F);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (got4() !== 25'd0 || got1() !== 25'd0) begin
         $display("FAIL reset_mid_async: dut4=%h dut1=%h required 0", got4(), got1());
      end else n_pass++;
      model_clear();
      step(8'h0F);
      #2 rst_n = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step(8'h0F);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL reset_mid[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
         if (j == 4 || j == 5) begin
            n_total++;
            if ({in4, rise4} !== ((j == 5) ? {8'h0F, 8'h0F} : {8'h00, 8'h00})) begin
               $display("FAIL reset_mid_latency e%0d: in=%h rise=%h", j, in4, rise4);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] cur = sw_raw;
      for (int j = 0; j < 600; j++) begin
         if ($urandom_range(0, 3) == 0) cur = cur ^ 8'($urandom);
         step(cur);
         n_total++;
         if (got4() !== exp4() || got1() !== exp1()) begin
            $display("FAIL random[%0d]: dut4=%h/%h dut1=%h/%h (got/required)",
                     j, got4(), exp4(), got1(), exp1());
         end else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_single_rise();
      test_stable_one();
      test_glitch();
      test_bounce();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
